// File: rtl/block_field.sv
// block_field: brick rows with pattern loader, hit probe and read/write pointer.
// Brick counting (blocks_left, field_empty) is compiled in only with BLOCK_FIELD_COUNT_EN.
module block_field #(
  parameter int NUM_ROWS = 15,
  parameter int ROW_WIDTH = 13,
  localparam int RW = $clog2(NUM_ROWS),
  localparam int CW = ROW_WIDTH > 1 ? $clog2(ROW_WIDTH) : 1,
  localparam int NW = $clog2(NUM_ROWS * ROW_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [ROW_WIDTH-1:0] line,
  output logic [RW-1:0]        line_idx,
  input  logic                 next_line,
  input  logic                 write_line,
  input  logic [ROW_WIDTH-1:0] new_line,
  input  logic                 load_level,
  input  logic [1:0]           level,
  input  logic                 hit_valid,
  input  logic [RW-1:0]        hit_row,
  input  logic [CW-1:0]        hit_col,
  output logic                 hit_done,
  output logic                 hit_brick,
  output logic                 busy,
  output logic [NW-1:0]        blocks_left,
  output logic                 field_empty
);
  typedef enum logic {IDLE, LOAD} state_e;
  localparam logic [RW-1:0] LAST = RW'(NUM_ROWS - 1);
  state_e state_q, state_d;
  logic [ROW_WIDTH-1:0] rows_q [NUM_ROWS];
  logic [ROW_WIDTH-1:0] rows_d [NUM_ROWS];
  logic [RW-1:0] idx_q, idx_d, ld_q, ld_d;
  logic [1:0] lvl_q, lvl_d;
  logic done_q, done_d, brick_q, brick_d;
  logic idle, acc, hit_ok, hit_set, wr_ok, nx_ok;
  logic [ROW_WIDTH-1:0] ld_pat;
  function automatic logic [ROW_WIDTH-1:0] pattern(input int r, input logic [1:0] l);
    logic [ROW_WIDTH-1:0] p;
    for (int c = 0; c < ROW_WIDTH; c++)
      p[c] = l == 2'd0 ? c < r - 1 : l == 2'd1 ? r >= 2 : l == 2'd2 ? r >= 2 && (r + c) % 2 == 1 : 1'b0;
    return p;
  endfunction
  assign idle = state_q == IDLE;
  assign busy = !idle;
  assign line_idx = idx_q;
  assign line = rows_q[idx_q];
  assign hit_done = done_q;
  assign hit_brick = brick_q;
  assign ld_pat = pattern(int'(ld_q), lvl_q);
  assign acc = idle && !load_level;
  assign hit_ok = acc && hit_valid && int'(hit_row) < NUM_ROWS && int'(hit_col) < ROW_WIDTH;
  assign hit_set = hit_ok && rows_q[hit_row][hit_col];
  // a hit owns its row for the cycle, so a write to the same row is dropped
  assign wr_ok = acc && write_line && !(hit_valid && hit_row == idx_q);
  assign nx_ok = acc && next_line && !wr_ok;
  always_comb begin
    rows_d = rows_q;
    state_d = state_q;
    idx_d = idx_q;
    ld_d = ld_q;
    lvl_d = lvl_q;
    done_d = acc && hit_valid;
    brick_d = hit_set;
    if (!idle) begin
      rows_d[ld_q] = ld_pat;
      ld_d = ld_q + 1'b1;
      state_d = ld_q == LAST ? IDLE : LOAD;
    end else if (load_level) begin
      lvl_d = level;
      ld_d = '0;
      state_d = LOAD;
    end else begin
      if (hit_set) rows_d[hit_row][hit_col] = 1'b0;
      if (wr_ok) rows_d[idx_q] = new_line;
      if (nx_ok) idx_d = idx_q == LAST ? '0 : idx_q + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= LOAD;
      rows_q <= '{default: '0};
      idx_q <= '0;
      ld_q <= '0;
      lvl_q <= '0;
      done_q <= 1'b0;
      brick_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q <= rows_d;
      idx_q <= idx_d;
      ld_q <= ld_d;
      lvl_q <= lvl_d;
      done_q <= done_d;
      brick_q <= brick_d;
    end
`ifdef BLOCK_FIELD_COUNT_EN
  logic [NW-1:0] cnt_q, cnt_d;
  function automatic logic [NW-1:0] pop(input logic [ROW_WIDTH-1:0] v);
    return NW'($countones(v));
  endfunction
  always_comb begin
    cnt_d = cnt_q - NW'(hit_set) + (wr_ok ? pop(new_line) - pop(rows_q[idx_q]) : '0);
    if (!idle) cnt_d = cnt_q + pop(ld_pat);
    else if (load_level) cnt_d = '0;
  end
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign blocks_left = cnt_q;
  assign field_empty = cnt_q == '0 && idle;
`else
  assign blocks_left = '0;
  assign field_empty = 1'b0;
`endif
endmodule

// File: tb/tb_block_field.sv
// tb_block_field: directed scenarios plus random traffic against a row-array reference model.
module tb_block_field;
  localparam int NR = 15;
  localparam int RWD = 13;
`ifdef BLOCK_FIELD_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic [RWD-1:0] line, new_line = '0;
  logic [3:0] line_idx, hit_row = '0, hit_col = '0;
  logic next_line = 1'b0, write_line = 1'b0, load_level = 1'b0, hit_valid = 1'b0;
  logic [1:0] level = '0;
  logic hit_done, hit_brick, busy, field_empty;
  logic [7:0] blocks_left;
  int n_checks = 0, n_errors = 0;
  logic [RWD-1:0] m_rows [NR];
  int m_idx = 0, m_lrow = 0, m_lvl = 0;
  bit m_loading = 1'b0, m_done = 1'b0, m_brick = 1'b0;

  block_field dut (
    .clk(clk), .rst(rst), .line(line), .line_idx(line_idx), .next_line(next_line),
    .write_line(write_line), .new_line(new_line), .load_level(load_level), .level(level),
    .hit_valid(hit_valid), .hit_row(hit_row), .hit_col(hit_col), .hit_done(hit_done),
    .hit_brick(hit_brick), .busy(busy), .blocks_left(blocks_left), .field_empty(field_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RWD-1:0] pat(input int r, input int l);
    logic [RWD-1:0] p = '0;
    int n = r - 1 < 0 ? 0 : r - 1;
    if (n > RWD) n = RWD;
    for (int c = 0; c < RWD; c++)
      case (l)
        0: p[c] = c < n;
        1: p[c] = r >= 2;
        2: p[c] = r >= 2 && (r + c) % 2 == 1;
        default: p[c] = 1'b0;
      endcase
    return p;
  endfunction

  function automatic int mcount();
    int s = 0;
    for (int r = 0; r < NR; r++)
      if (!m_loading || r < m_lrow) s += $countones(m_rows[r]);
    return s;
  endfunction

  task automatic model_step();
    bit same;
    m_done = 1'b0;
    m_brick = 1'b0;
    if (rst) begin
      for (int r = 0; r < NR; r++) m_rows[r] = '0;
      m_idx = 0;
      m_loading = 1'b1;
      m_lrow = 0;
      m_lvl = 0;
    end else if (m_loading) begin
      m_rows[m_lrow] = pat(m_lrow, m_lvl);
      if (m_lrow == NR - 1) m_loading = 1'b0;
      else m_lrow++;
    end else if (load_level) begin
      m_loading = 1'b1;
      m_lrow = 0;
      m_lvl = int'(level);
    end else begin
      same = 1'b0;
      if (hit_valid) begin
        m_done = 1'b1;
        same = int'(hit_row) == m_idx;
        if (hit_row < NR && hit_col < RWD && m_rows[hit_row][hit_col]) begin
          m_brick = 1'b1;
          m_rows[hit_row][hit_col] = 1'b0;
        end
      end
      if (write_line && !same) m_rows[m_idx] = new_line;
      else if (next_line) m_idx = (m_idx + 1) % NR;
    end
  endtask

  task automatic tick();
    int c;
    @(posedge clk);
    model_step();
    #1;
    c = mcount();
    check("line", line, m_rows[m_idx]);
    check("line_idx", line_idx, m_idx);
    check("busy", busy, m_loading);
    check("hit_done", hit_done, m_done);
    check("hit_brick", hit_brick, m_brick);
    check("blocks_left", blocks_left, CNT_EN ? c : 0);
    check("field_empty", field_empty, CNT_EN && c == 0 && !m_loading);
  endtask

  task automatic clear_in();
    rst = 1'b0; next_line = 1'b0; write_line = 1'b0; load_level = 1'b0; hit_valid = 1'b0;
  endtask

  task automatic busy_len(input string tag);
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check(tag, n, NR);
  endtask

  task automatic hit(input int r, input int c);
    hit_valid = 1'b1; hit_row = 4'(r); hit_col = 4'(c);
    tick();
    clear_in();
  endtask

  initial begin
    int base, w;
    rst = 1'b1;
    tick();
    check("rst_busy", busy, 1);
    check("rst_idx", line_idx, 0);
    check("rst_done", hit_done, 0);
    rst = 1'b0;
    busy_len("busy_after_rst");
    check("row0", line, 0);
    check("blocks91", blocks_left, CNT_EN ? 91 : 0);
    for (int i = 0; i < NR; i++) begin
      next_line = 1'b1;
      tick();
      next_line = 1'b0;
      check("walk_idx", line_idx, (i + 1) % NR);
      if ((i + 1) % NR == 14) check("row14", line, 13'h1FFF);
      if ((i + 1) % NR == 2) check("row2", line, 13'h0001);
    end
    hit(14, 0);
    check("hit1_done", hit_done, 1);
    check("hit1_brick", hit_brick, 1);
    check("hit1_cnt", blocks_left, CNT_EN ? 90 : 0);
    hit(14, 0);
    check("hit2_brick", hit_brick, 0);
    check("hit2_cnt", blocks_left, CNT_EN ? 90 : 0);
    hit(5, 13);
    check("oor_col_done", hit_done, 1);
    check("oor_col_brick", hit_brick, 0);
    hit(15, 0);
    check("oor_row_done", hit_done, 1);
    check("oor_row_brick", hit_brick, 0);
    check("oor_cnt", blocks_left, CNT_EN ? 90 : 0);
    repeat (2) begin
      next_line = 1'b1;
      tick();
      next_line = 1'b0;
    end
    base = mcount();
    write_line = 1'b1; new_line = 13'h1FFF;
    tick();
    clear_in();
    check("wr_row2", line, 13'h1FFF);
    check("wr_cnt", blocks_left, CNT_EN ? base + 12 : 0);
    write_line = 1'b1; new_line = 13'h0000; hit_valid = 1'b1; hit_row = 4'd2; hit_col = 4'd3;
    tick();
    clear_in();
    check("hit_wins_row", line, 13'h1FF7);
    load_level = 1'b1; level = 2'd3;
    tick();
    clear_in();
    for (int i = 0; i < NR; i++) begin
      hit_valid = 1'b1; hit_row = 4'(i); hit_col = 4'd4; next_line = 1'b1;
      tick();
      check("busy_nohit", hit_done, 0);
    end
    clear_in();
    check("lvl3_busy", busy, 0);
    check("lvl3_empty", field_empty, CNT_EN);
    load_level = 1'b1; level = 2'd1;
    tick();
    clear_in();
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    busy_len("busy_restart");
    for (int i = 0; i < 700; i++) begin
      w = int'($urandom_range(99));
      rst = w == 0;
      load_level = w >= 1 && w < 3;
      level = 2'($urandom_range(3));
      hit_valid = $urandom_range(99) < 35;
      hit_row = 4'($urandom_range(15));
      hit_col = 4'($urandom_range(15));
      w = int'($urandom_range(2));
      write_line = !hit_valid && w == 1;
      next_line = w == 2;
      new_line = RWD'($urandom);
      tick();
      clear_in();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
